// File: rtl/pifo_sram_pkg.sv
// Shared types and constants for the multi-tree PIFO block.
package pifo_sram_pkg;

    localparam int TASK_TID_W  = 8;
    localparam int TASK_DATA_W = 64;

    typedef struct packed {
        logic [TASK_TID_W-1:0]  tree_id;
        logic                   push;
        logic                   pop;
        logic [TASK_DATA_W-1:0] data;
    } pifo_task_t;

    // Value returned when popping an empty tree.
    localparam logic [TASK_DATA_W-1:0] EMPTY_SENTINEL = '1;

    // Entries per tree: 8 + 64 + ... + 8^level.
    function automatic int pifo_cap(input int level);
        int p8;
        p8 = 1;
        for (int unsigned i = 0; i < level; i++) p8 = p8 * 8;
        return 8 * (p8 - 1) / 7;
    endfunction

endpackage

// File: rtl/pifo_vq.sv
// One virtual PIFO: a sorted shift register of CAP entries with an occupancy counter.
module pifo_vq
    import pifo_sram_pkg::*;
#(
    parameter int PTW = 16,
    parameter int CTW = 16,
    parameter int CAP = 72
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    input  logic           op_push,
    input  logic           op_pop,
    input  logic [PTW-1:0] op_data,
    output logic [PTW-1:0] pop_data
);

    logic [PTW-1:0] entry      [0:CAP-1];
    logic [PTW-1:0] entry_nxt  [0:CAP-1];
    logic [PTW-1:0] e_prev     [0:CAP-1];
    logic [PTW-1:0] e_next     [0:CAP-1];
    logic [CTW-1:0] count, count_nxt;
    logic [CAP:0]   le;
    logic [CAP-1:0] lp;
    logic           ins, rem, empty, full;

    assign empty = (count == '0);
    assign full  = (count == CTW'(CAP));

    // le[i]: slot i is occupied and not greater than the new value, so the
    // new value goes after it (keeps equal values in arrival order).
    always_comb begin
        le = '0;
        for (int unsigned i = 0; i < CAP; i++)
            le[i] = (CTW'(i) < count) && (entry[i] <= op_data);
        lp = {le[CAP-2:0], 1'b1};
        e_prev[0]     = op_data;
        e_next[CAP-1] = entry[CAP-1];
        for (int unsigned i = 1; i < CAP; i++) begin
            e_prev[i]   = entry[i-1];
            e_next[i-1] = entry[i];
        end
    end

    always_comb begin
        ins      = 1'b0;
        rem      = 1'b0;
        pop_data = EMPTY_SENTINEL[PTW-1:0];
        if (op_valid) begin
            if (op_pop && !op_push) begin
                if (!empty) begin
                    rem      = 1'b1;
                    pop_data = entry[0];
                end
            end else if (op_push && !op_pop) begin
                ins = !full;
            end else if (op_push && op_pop) begin
                if (full) begin
                    rem      = 1'b1;
                    pop_data = entry[0];
                end else if (le[0]) begin
                    rem      = 1'b1;
                    ins      = 1'b1;
                    pop_data = entry[0];
                end else begin
                    pop_data = op_data;
                end
            end
        end
    end

    // Replace = remove head then insert into the left-shifted array.
    always_comb begin
        entry_nxt = entry;
        count_nxt = count;
        for (int unsigned i = 0; i < CAP; i++) begin
            case ({ins, rem})
                2'b10:   entry_nxt[i] = le[i] ? entry[i] : (lp[i] ? op_data : e_prev[i]);
                2'b01:   entry_nxt[i] = e_next[i];
                2'b11:   entry_nxt[i] = le[i+1] ? e_next[i] : (le[i] ? op_data : entry[i]);
                default: entry_nxt[i] = entry[i];
            endcase
        end
        if (ins && !rem)      count_nxt = count + CTW'(1);
        else if (rem && !ins) count_nxt = count - CTW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_nxt;
    end

    always_ff @(posedge clk) begin
        entry <= entry_nxt;
    end

endmodule

// File: rtl/pifo_sram_top.sv
// Multi-port PIFO: per-port task FIFOs arbitrated onto TREE_NUM sorted trees.
module pifo_sram_top
    import pifo_sram_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int CTW       = 16,
    parameter int LEVEL     = 2,
    parameter int TREE_NUM  = 6,
    parameter int FIFO_SIZE = 16,
    localparam int TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [TREE_NUM_BITS-1:0] i_tree_id [0:LEVEL-1],
    input  logic [LEVEL-1:0]         i_push,
    input  logic [PTW-1:0]           i_push_data [0:LEVEL-1],
    input  logic [LEVEL-1:0]         i_pop,
    output logic [PTW-1:0]           o_pop_data [0:LEVEL-1],
    output logic [LEVEL-1:0]         o_task_fifo_full
);

    localparam int ENTRY_W = PTW + MTW;
    localparam int CAP     = pifo_cap(LEVEL);
    localparam int FPW     = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam int FCW     = $clog2(FIFO_SIZE + 1);

    pifo_task_t       fifo_mem     [0:LEVEL-1][0:FIFO_SIZE-1];
    pifo_task_t       head         [0:LEVEL-1];
    logic [FPW-1:0]   rd_ptr       [0:LEVEL-1];
    logic [FPW-1:0]   wr_ptr       [0:LEVEL-1];
    logic [FCW-1:0]   fifo_cnt     [0:LEVEL-1];
    logic [FCW-1:0]   fifo_cnt_nxt [0:LEVEL-1];
    logic [LEVEL-1:0] head_valid, issue, enq, pop_hit, unused_data_hi;
    logic [ENTRY_W-1:0] pop_sel    [0:LEVEL-1];

    logic [TREE_NUM-1:0] op_valid, op_push, op_pop;
    logic [ENTRY_W-1:0]  op_data       [0:TREE_NUM-1];
    logic [ENTRY_W-1:0]  tree_pop_data [0:TREE_NUM-1];

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == FPW'(FIFO_SIZE - 1)) ? '0 : p + FPW'(1);
    endfunction

    // Lower-indexed port wins when two heads target the same tree.
    always_comb begin
        for (int unsigned j = 0; j < LEVEL; j++) begin
            head[j]           = fifo_mem[j][rd_ptr[j]];
            head_valid[j]     = (fifo_cnt[j] != '0);
            enq[j]            = (i_push[j] || i_pop[j]) && !o_task_fifo_full[j];
            unused_data_hi[j] = ^head[j].data[TASK_DATA_W-1:ENTRY_W];
        end
        for (int unsigned j = 0; j < LEVEL; j++) begin
            issue[j] = head_valid[j];
            for (int unsigned k = 0; k < j; k++)
                if (head_valid[k] && head[k].tree_id == head[j].tree_id) issue[j] = 1'b0;
            case ({enq[j], issue[j]})
                2'b10:   fifo_cnt_nxt[j] = fifo_cnt[j] + FCW'(1);
                2'b01:   fifo_cnt_nxt[j] = fifo_cnt[j] - FCW'(1);
                default: fifo_cnt_nxt[j] = fifo_cnt[j];
            endcase
        end
    end

    always_comb begin
        op_valid = '0;
        op_push  = '0;
        op_pop   = '0;
        pop_hit  = '0;
        for (int unsigned t = 0; t < TREE_NUM; t++) op_data[t] = '0;
        for (int unsigned j = 0; j < LEVEL; j++) pop_sel[j] = '0;
        for (int unsigned t = 0; t < TREE_NUM; t++) begin
            for (int unsigned j = 0; j < LEVEL; j++) begin
                if (issue[j] && head[j].tree_id == TASK_TID_W'(t)) begin
                    op_valid[t] = 1'b1;
                    op_push[t]  = head[j].push;
                    op_pop[t]   = head[j].pop;
                    op_data[t]  = head[j].data[ENTRY_W-1:0];
                    pop_hit[j]  = head[j].pop;
                    pop_sel[j]  = tree_pop_data[t];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_task_fifo_full <= '0;
            for (int unsigned j = 0; j < LEVEL; j++) begin
                rd_ptr[j]     <= '0;
                wr_ptr[j]     <= '0;
                fifo_cnt[j]   <= '0;
                o_pop_data[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < LEVEL; j++) begin
                if (enq[j]) begin
                    fifo_mem[j][wr_ptr[j]] <= '{tree_id: TASK_TID_W'(i_tree_id[j]),
                                                push:    i_push[j],
                                                pop:     i_pop[j],
                                                data:    TASK_DATA_W'(i_push_data[j])};
                    wr_ptr[j] <= ptr_inc(wr_ptr[j]);
                end
                if (issue[j]) rd_ptr[j] <= ptr_inc(rd_ptr[j]);
                if (pop_hit[j]) o_pop_data[j] <= pop_sel[j];
                fifo_cnt[j]         <= fifo_cnt_nxt[j];
                o_task_fifo_full[j] <= (fifo_cnt_nxt[j] == FCW'(FIFO_SIZE));
            end
        end
    end

    for (genvar t = 0; t < TREE_NUM; t++) begin : g_tree
        pifo_vq #(
            .PTW (ENTRY_W),
            .CTW (CTW),
            .CAP (CAP)
        ) u_vq (
            .clk      (i_clk),
            .rst      (i_rst),
            .op_valid (op_valid[t]),
            .op_push  (op_push[t]),
            .op_pop   (op_pop[t]),
            .op_data  (op_data[t]),
            .pop_data (tree_pop_data[t])
        );
    end

endmodule

// File: tb/tb_pifo_sram_top.sv
// Bench for pifo_sram_top: queue-based reference model plus directed literal checks.
module tb_pifo_sram_top;

    localparam int PTW       = 16;
    localparam int LEVEL     = 2;
    localparam int TREE_NUM  = 6;
    localparam int FIFO_SIZE = 16;
    localparam int TNB       = 3;
    localparam int CAP       = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [TNB-1:0]   tree_id   [0:LEVEL-1];
    logic [LEVEL-1:0] req_push, req_pop;
    logic [PTW-1:0]   push_data [0:LEVEL-1];
    logic [PTW-1:0]   pop_data  [0:LEVEL-1];
    logic [LEVEL-1:0] fifo_full;

    pifo_sram_top #(
        .PTW       (PTW),
        .MTW       (0),
        .CTW       (16),
        .LEVEL     (LEVEL),
        .TREE_NUM  (TREE_NUM),
        .FIFO_SIZE (FIFO_SIZE)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tree_id        (tree_id),
        .i_push           (req_push),
        .i_push_data      (push_data),
        .i_pop            (req_pop),
        .o_pop_data       (pop_data),
        .o_task_fifo_full (fifo_full)
    );

    typedef struct {
        int           tid;
        bit           push;
        bit           pop;
        logic [PTW-1:0] data;
    } mtask_t;

    mtask_t         pq [LEVEL][$];
    logic [PTW-1:0] tq [TREE_NUM][$];
    logic [PTW-1:0] exp_pop [LEVEL];
    logic [LEVEL-1:0] exp_full;
    int total = 0;
    int bad   = 0;

    // Reference tree operation: sorted list, stable insert, min removal.
    task automatic tree_op(input int t, input bit ps, input bit pp, input logic [PTW-1:0] d,
                           output logic [PTW-1:0] r);
        int idx;
        r = '1;
        if (ps && pp && tq[t].size() == CAP) begin
            r = tq[t].pop_front();
            return;
        end
        if (ps && tq[t].size() < CAP) begin
            idx = tq[t].size();
            for (int i = 0; i < tq[t].size(); i++)
                if (tq[t][i] > d) begin idx = i; break; end
            tq[t].insert(idx, d);
        end
        if (pp && tq[t].size() > 0) r = tq[t].pop_front();
    endtask

    // Advances the model across the next rising edge using the current inputs.
    task automatic model_step();
        int pre [LEVEL];
        bit iss [LEVEL];
        mtask_t m;
        logic [PTW-1:0] r;
        if (rst) begin
            for (int j = 0; j < LEVEL; j++) begin pq[j].delete(); exp_pop[j] = '0; end
            for (int t = 0; t < TREE_NUM; t++) tq[t].delete();
            exp_full = '0;
            return;
        end
        for (int j = 0; j < LEVEL; j++) pre[j] = pq[j].size();
        for (int j = 0; j < LEVEL; j++) begin
            iss[j] = pre[j] > 0;
            for (int k = 0; k < j; k++)
                if (pre[k] > 0 && pre[j] > 0 && pq[k][0].tid == pq[j][0].tid) iss[j] = 0;
        end
        for (int j = 0; j < LEVEL; j++) begin
            if (iss[j]) begin
                m = pq[j].pop_front();
                if (m.tid < TREE_NUM) begin
                    tree_op(m.tid, m.push, m.pop, m.data, r);
                    if (m.pop) exp_pop[j] = r;
                end
            end
        end
        for (int j = 0; j < LEVEL; j++) begin
            if ((req_push[j] || req_pop[j]) && pre[j] < FIFO_SIZE)
                pq[j].push_back('{int'(tree_id[j]), req_push[j], req_pop[j], push_data[j]});
            exp_full[j] = (pq[j].size() == FIFO_SIZE);
        end
    endtask

    task automatic check(input string name, input logic [PTW-1:0] got, input logic [PTW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < LEVEL; j++) begin
            check($sformatf("model_pop_data[%0d]", j), pop_data[j], exp_pop[j]);
            check($sformatf("model_fifo_full[%0d]", j), PTW'(fifo_full[j]), PTW'(exp_full[j]));
        end
    endtask

    task automatic set_idle();
        req_push = '0;
        req_pop  = '0;
        for (int j = 0; j < LEVEL; j++) begin
            tree_id[j]   = '0;
            push_data[j] = '0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        cycle();
        cycle();
        check("reset_pop0", pop_data[0], '0);
        check("reset_pop1", pop_data[1], '0);
        check("reset_full", PTW'(fifo_full), '0);
        rst = 1'b0;

        // Fill trees 0/1 to capacity, then one extra push each that must be dropped.
        for (int i = 0; i <= CAP; i++) begin
            for (int j = 0; j < LEVEL; j++) begin
                tree_id[j]   = TNB'(j);
                req_push[j]  = 1'b1;
                push_data[j] = PTW'(4096 * j + ((i == CAP) ? 1 : i));
            end
            cycle();
        end
        set_idle();

        for (int s = 0; s <= CAP + 1; s++) begin
            for (int j = 0; j < LEVEL; j++) begin
                tree_id[j] = TNB'(j);
                req_pop[j] = (s <= CAP);
            end
            cycle();
            if (s >= 1)
                for (int j = 0; j < LEVEL; j++)
                    check("drain", pop_data[j],
                          (s - 1 < CAP) ? PTW'(4096 * j + s - 1) : 16'hFFFF);
        end
        set_idle();
        cycle();

        // Ordering with duplicates on tree 2.
        begin
            logic [PTW-1:0] vals [4] = '{16'd5, 16'd3, 16'd3, 16'd9};
            logic [PTW-1:0] outs [4] = '{16'd3, 16'd3, 16'd5, 16'd9};
            for (int i = 0; i < 4; i++) begin
                tree_id[0] = 3'd2; req_push[0] = 1'b1; push_data[0] = vals[i];
                cycle();
            end
            set_idle();
            cycle();
            for (int i = 0; i < 4; i++) begin
                tree_id[0] = 3'd2; req_pop[0] = 1'b1;
                cycle();
                set_idle();
                cycle();
                check("order", pop_data[0], outs[i]);
            end
        end

        // Contention on tree 4: port 0 wins every cycle, port 1 backs up.
        for (int i = 0; i < 40; i++) begin
            tree_id[0] = 3'd4; req_push[0] = 1'b1; push_data[0] = PTW'(1000 + i);
            cycle();
        end
        set_idle();
        cycle();
        cycle();
        for (int s = 0; s < FIFO_SIZE + 2; s++) begin
            for (int j = 0; j < LEVEL; j++) begin
                tree_id[j] = 3'd4;
                req_pop[j] = 1'b1;
            end
            cycle();
            if (s == FIFO_SIZE - 2) check("contend_not_full", PTW'(fifo_full[1]), 16'd0);
            if (s == FIFO_SIZE - 1) check("contend_full", PTW'(fifo_full[1]), 16'd1);
        end
        set_idle();
        for (int i = 0; i < 25; i++) cycle();
        check("contend_port0_last", pop_data[0], 16'd1017);
        check("contend_port1_last", pop_data[1], 16'd1033);

        // Reset with entries queued and stored.
        for (int i = 0; i < 10; i++) begin
            tree_id[0] = 3'd3; req_push[0] = 1'b1; push_data[0] = PTW'(10 + i);
            cycle();
        end
        rst = 1'b1;
        cycle();
        check("rst_mid_pop0", pop_data[0], '0);
        check("rst_mid_pop1", pop_data[1], '0);
        check("rst_mid_full", PTW'(fifo_full), '0);
        rst = 1'b0;
        set_idle();
        cycle();
        tree_id[0] = 3'd3; req_pop[0] = 1'b1;
        cycle();
        set_idle();
        cycle();
        check("rst_empty_pop", pop_data[0], 16'hFFFF);

        // Random traffic: push-heavy first half, pop-heavy second half.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 799) == 0);
            for (int j = 0; j < LEVEL; j++) begin
                if (c < 1500) begin
                    req_push[j] = ($urandom_range(0, 9) < 8);
                    req_pop[j]  = ($urandom_range(0, 9) < 3);
                end else begin
                    req_push[j] = ($urandom_range(0, 9) < 3);
                    req_pop[j]  = ($urandom_range(0, 9) < 7);
                end
                tree_id[j]   = ($urandom_range(0, 19) == 0) ? TNB'($urandom_range(6, 7))
                                                            : TNB'($urandom_range(0, 5));
                push_data[j] = ($urandom_range(0, 49) == 0) ? 16'hFFFF
                                                            : PTW'($urandom_range(0, 40));
            end
            cycle();
        end
        rst = 1'b0;
        set_idle();
        for (int i = 0; i < 40; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
